branch_redirect_ctrl: RTL and testbench

Sequences the PC redirect and pipeline flush that follow a taken branch or jump in the RV64 core. Sits between the EX-stage branch/jump resolution logic and the fetch unit. Registers the resolved target, holds a valid/ready redirect handshake to fetch, and drives IF/ID flush for a programmable window. Also flags misaligned targets and keeps a saturating taken-redirect counter.

---
 rtl/branch_redirect_ctrl_pkg.sv | 13 +
 rtl/sat_counter.sv | 31 +++
 rtl/branch_redirect_ctrl.sv | 124 ++++++++++++
 tb/tb_branch_redirect_ctrl.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/branch_redirect_ctrl_pkg.sv
// rtl/branch_redirect_ctrl_pkg.sv - shared state encodings and constants for the branch redirect controller
package branch_redirect_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_REQ   = 2'd1,
    ST_FLUSH = 2'd2
  } brc_state_e;

  localparam int DEFAULT_FLUSH_CYCLES = 2;
  localparam int FLUSH_CNT_W          = 4;

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating up-counter, reusable for performance counters
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk_in,
  input  logic         rst_in,
  input  logic         inc_in,
  output logic [W-1:0] cnt_out
);

  logic [W-1:0] cnt_d;
  logic [W-1:0] cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (inc_in && (cnt_q != {W{1'b1}})) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_out = cnt_q;

endmodule

// File: rtl/branch_redirect_ctrl.sv
// rtl/branch_redirect_ctrl.sv - PC redirect handshake and IF/ID flush sequencing after a taken branch/jump
module branch_redirect_ctrl
  import branch_redirect_ctrl_pkg::*;
#(
  parameter int XLEN         = 64,
  parameter int FLUSH_CYCLES = DEFAULT_FLUSH_CYCLES,
  parameter int CNT_W        = 32
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             ex_valid_in,
  input  logic             stall_in,
  input  logic             branch_jump_signal_in,
  input  logic [XLEN-1:0]  target_pc_in,
  input  logic             fetch_ready_in,
  output logic             redirect_valid_out,
  output logic [XLEN-1:0]  redirect_pc_out,
  output logic             flush_if_out,
  output logic             flush_id_out,
  output logic             busy_out,
  output logic             misalign_out,
  output logic [CNT_W-1:0] taken_cnt_out
);

  localparam logic [FLUSH_CNT_W-1:0] FLUSH_LOAD =
    FLUSH_CNT_W'((FLUSH_CYCLES > 0) ? (FLUSH_CYCLES - 1) : 0);

  brc_state_e             state_d, state_q;
  logic                   redirect_valid_d, redirect_valid_q;
  logic [XLEN-1:0]        redirect_pc_d, redirect_pc_q;
  logic                   flush_d, flush_q;
  logic                   misalign_d, misalign_q;
  logic [FLUSH_CNT_W-1:0] fcnt_d, fcnt_q;
  logic                   take;
  logic                   accept;

  always_comb begin
    take   = (state_q == ST_IDLE) & ex_valid_in & ~stall_in & branch_jump_signal_in;
    accept = (state_q == ST_REQ) & fetch_ready_in;

    state_d          = state_q;
    redirect_valid_d = redirect_valid_q;
    redirect_pc_d    = redirect_pc_q;
    flush_d          = flush_q;
    misalign_d       = 1'b0;
    fcnt_d           = fcnt_q;

    case (state_q)
      ST_IDLE: begin
        if (take) begin
          if (target_pc_in[1:0] == 2'b00) begin
            state_d          = ST_REQ;
            redirect_valid_d = 1'b1;
            redirect_pc_d    = target_pc_in;
            flush_d          = 1'b1;
          end else begin
            misalign_d = 1'b1;
          end
        end
      end
      ST_REQ: begin
        if (accept) begin
          redirect_valid_d = 1'b0;
          if (FLUSH_CYCLES == 0) begin
            state_d = ST_IDLE;
            flush_d = 1'b0;
          end else begin
            state_d = ST_FLUSH;
            fcnt_d  = FLUSH_LOAD;
          end
        end
      end
      ST_FLUSH: begin
        // Counter was loaded with N-1 so flush spans exactly N cycles here
        if (fcnt_q == '0) begin
          state_d = ST_IDLE;
          flush_d = 1'b0;
        end else begin
          fcnt_d = fcnt_q - FLUSH_CNT_W'(1);
        end
      end
      default: begin
        state_d          = ST_IDLE;
        redirect_valid_d = 1'b0;
        flush_d          = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q          <= ST_IDLE;
      redirect_valid_q <= 1'b0;
      redirect_pc_q    <= '0;
      flush_q          <= 1'b0;
      misalign_q       <= 1'b0;
      fcnt_q           <= '0;
    end else begin
      state_q          <= state_d;
      redirect_valid_q <= redirect_valid_d;
      redirect_pc_q    <= redirect_pc_d;
      flush_q          <= flush_d;
      misalign_q       <= misalign_d;
      fcnt_q           <= fcnt_d;
    end
  end

  sat_counter #(
    .W(CNT_W)
  ) u_taken_cnt (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .inc_in (accept),
    .cnt_out(taken_cnt_out)
  );

  assign redirect_valid_out = redirect_valid_q;
  assign redirect_pc_out    = redirect_pc_q;
  assign flush_if_out       = flush_q;
  assign flush_id_out       = flush_q;
  assign misalign_out       = misalign_q;
  assign busy_out           = (state_q != ST_IDLE);

endmodule

// File: tb/tb_branch_redirect_ctrl.sv
// tb/tb_branch_redirect_ctrl.sv - directed self-checking bench for branch_redirect_ctrl
module tb_branch_redirect_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        ex_valid, stall, bj, ready;
  logic [63:0] target;
  logic        rv, fif, fid, busy, mis;
  logic [63:0] pc;
  logic [31:0] cnt;

  logic        ex_valid0, stall0, bj0, ready0;
  logic [63:0] target0;
  logic        rv0, fif0, fid0, busy0, mis0;
  logic [63:0] pc0;
  logic [1:0]  cnt0;

  logic [4:0]  flags, flags0;
  assign flags  = {rv, fif, fid, busy, mis};
  assign flags0 = {rv0, fif0, fid0, busy0, mis0};

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  branch_redirect_ctrl u_dut (
    .clk_in(clk), .rst_in(rst), .ex_valid_in(ex_valid), .stall_in(stall),
    .branch_jump_signal_in(bj), .target_pc_in(target), .fetch_ready_in(ready),
    .redirect_valid_out(rv), .redirect_pc_out(pc), .flush_if_out(fif),
    .flush_id_out(fid), .busy_out(busy), .misalign_out(mis), .taken_cnt_out(cnt)
  );

  branch_redirect_ctrl #(.XLEN(64), .FLUSH_CYCLES(0), .CNT_W(2)) u_dut0 (
    .clk_in(clk), .rst_in(rst), .ex_valid_in(ex_valid0), .stall_in(stall0),
    .branch_jump_signal_in(bj0), .target_pc_in(target0), .fetch_ready_in(ready0),
    .redirect_valid_out(rv0), .redirect_pc_out(pc0), .flush_if_out(fif0),
    .flush_id_out(fid0), .busy_out(busy0), .misalign_out(mis0), .taken_cnt_out(cnt0)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    ex_valid = 0; stall = 0; bj = 0; ready = 0; target = '0;
  endtask

  // flags order: {redirect_valid, flush_if, flush_id, busy, misalign}
  task automatic test_reset();
    rst = 1; ex_valid = 1; stall = 1; bj = 1; ready = 1; target = '1;
    ex_valid0 = 1; stall0 = 1; bj0 = 1; ready0 = 1; target0 = '1;
    for (int i = 0; i < 3; i++) begin
      step();
      n_cmp++;
      if ({flags, pc, cnt} !== '0) begin
        n_bad++;
        $display("FAIL reset_main cyc%0d: flags=%b pc=%h cnt=%0d, expected all 0", i, flags, pc, cnt);
      end
      n_cmp++;
      if ({flags0, pc0, cnt0} !== '0) begin
        n_bad++;
        $display("FAIL reset_fc0 cyc%0d: flags=%b pc=%h cnt=%0d, expected all 0", i, flags0, pc0, cnt0);
      end
    end
    rst = 0;
    idle_inputs();
    ex_valid0 = 0; stall0 = 0; bj0 = 0; ready0 = 0; target0 = '0;
    step();
  endtask

  task automatic test_accept();
    ex_valid = 1; bj = 1; target = 64'h1000;
    step();
    idle_inputs();
    n_cmp++;
    if (flags !== 5'b11110 || pc !== 64'h1000) begin
      n_bad++; $display("FAIL accept_req: flags=%b pc=%h, expected 11110 pc=1000", flags, pc);
    end
    ready = 1;
    step();
    ready = 0;
    n_cmp++;
    if (flags !== 5'b01110 || cnt !== 32'd1) begin
      n_bad++; $display("FAIL accept_flush1: flags=%b cnt=%0d, expected 01110 cnt=1", flags, cnt);
    end
    step();
    n_cmp++;
    if (flags !== 5'b01110) begin
      n_bad++; $display("FAIL accept_flush2: flags=%b, expected 01110", flags);
    end
    step();
    n_cmp++;
    if (flags !== 5'b00000 || cnt !== 32'd1) begin
      n_bad++; $display("FAIL accept_idle: flags=%b cnt=%0d, expected 00000 cnt=1", flags, cnt);
    end
  endtask

  task automatic test_hold();
    ex_valid = 1; bj = 1; target = 64'h2000;
    step();
    idle_inputs();
    for (int i = 0; i < 5; i++) begin
      if (i == 2) begin
        ex_valid = 1; bj = 1; target = 64'h3000;
      end else begin
        idle_inputs();
      end
      n_cmp++;
      if (flags !== 5'b11110 || pc !== 64'h2000 || cnt !== 32'd1) begin
        n_bad++; $display("FAIL hold_wait%0d: flags=%b pc=%h cnt=%0d, expected 11110 pc=2000 cnt=1", i, flags, pc, cnt);
      end
      step();
    end
    idle_inputs();
    ready = 1;
    step();
    ready = 0;
    step();
    step();
    n_cmp++;
    if (flags !== 5'b00000 || cnt !== 32'd2 || pc !== 64'h2000) begin
      n_bad++; $display("FAIL hold_done: flags=%b pc=%h cnt=%0d, expected 00000 pc=2000 cnt=2", flags, pc, cnt);
    end
  endtask

  task automatic test_misalign();
    ex_valid = 1; bj = 1; target = 64'h1002;
    step();
    idle_inputs();
    n_cmp++;
    if (flags !== 5'b00001) begin
      n_bad++; $display("FAIL misalign_pulse: flags=%b, expected 00001", flags);
    end
    step();
    n_cmp++;
    if (flags !== 5'b00000 || cnt !== 32'd2) begin
      n_bad++; $display("FAIL misalign_after: flags=%b cnt=%0d, expected 00000 cnt=2", flags, cnt);
    end
  endtask

  task automatic test_stall();
    ex_valid = 1; bj = 1; stall = 1; target = 64'h4000;
    step();
    n_cmp++;
    if (flags !== 5'b00000) begin
      n_bad++; $display("FAIL stall_ignored: flags=%b, expected 00000", flags);
    end
    stall = 0;
    step();
    idle_inputs();
    n_cmp++;
    if (flags !== 5'b11110 || pc !== 64'h4000) begin
      n_bad++; $display("FAIL stall_release: flags=%b pc=%h, expected 11110 pc=4000", flags, pc);
    end
    stall = 1; ready = 1;
    step();
    idle_inputs();
    n_cmp++;
    if (flags !== 5'b01110 || cnt !== 32'd3) begin
      n_bad++; $display("FAIL stall_accept: flags=%b cnt=%0d, expected 01110 cnt=3", flags, cnt);
    end
    step();
    step();
  endtask

  task automatic test_reset_mid();
    ex_valid = 1; bj = 1; target = 64'h5000;
    step();
    idle_inputs();
    rst = 1; ready = 1;
    step();
    rst = 0; ready = 0;
    n_cmp++;
    if ({flags, pc, cnt} !== '0) begin
      n_bad++; $display("FAIL reset_in_req: flags=%b pc=%h cnt=%0d, expected all 0", flags, pc, cnt);
    end
    ex_valid = 1; bj = 1; target = 64'h6000;
    step();
    idle_inputs();
    ready = 1;
    step();
    ready = 0;
    n_cmp++;
    if (flags !== 5'b01110 || cnt !== 32'd1) begin
      n_bad++; $display("FAIL reset_pre_flush: flags=%b cnt=%0d, expected 01110 cnt=1", flags, cnt);
    end
    rst = 1;
    step();
    rst = 0;
    n_cmp++;
    if ({flags, pc, cnt} !== '0) begin
      n_bad++; $display("FAIL reset_in_flush: flags=%b pc=%h cnt=%0d, expected all 0", flags, pc, cnt);
    end
    step();
    n_cmp++;
    if (flags !== 5'b00000) begin
      n_bad++; $display("FAIL reset_stays_idle: flags=%b, expected 00000", flags);
    end
  endtask

  task automatic test_flush0_saturate();
    logic [1:0] exp_cnt;
    for (int k = 0; k < 4; k++) begin
      exp_cnt = (k >= 3) ? 2'd3 : 2'(k + 1);
      ex_valid0 = 1; bj0 = 1; target0 = 64'h100 + 64'(k * 16);
      step();
      ex_valid0 = 0; bj0 = 0;
      n_cmp++;
      if (flags0 !== 5'b11110 || pc0 !== 64'h100 + 64'(k * 16)) begin
        n_bad++; $display("FAIL fc0_req%0d: flags=%b pc=%h, expected 11110 pc=%h", k, flags0, pc0, 64'h100 + 64'(k * 16));
      end
      ready0 = 1;
      step();
      ready0 = 0;
      n_cmp++;
      if (flags0 !== 5'b00000 || cnt0 !== exp_cnt) begin
        n_bad++; $display("FAIL fc0_accept%0d: flags=%b cnt=%0d, expected 00000 cnt=%0d", k, flags0, cnt0, exp_cnt);
      end
    end
  endtask

  initial begin
    test_reset();
    test_accept();
    test_hold();
    test_misalign();
    test_stall();
    test_reset_mid();
    test_flush0_saturate();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
